// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: synchronizes the async reset, then releases three
// active-low domain resets in order, with a software re-sequence path.
module reset_seq_ctrl #(
    parameter int HOLD_CYC = 16,
    parameter int GAP_CYC  = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_async_n,
    input  logic       sw_rst_req,
    output logic [2:0] rst_n_o,
    output logic       sys_ready,
    output logic       sw_rst_ack
);

    typedef enum logic [1:0] {S_HOLD, S_SEQ0, S_SEQ1, S_RUN} state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             rst_int_n;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       rst_n_q, rst_n_d;
    logic             ready_q, ready_d;
    logic             ack_q, ack_d;

    // Reset is asserted asynchronously but released only through two flops.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = sync_q[1];

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            rst_n_q <= 3'b000;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_n_q <= rst_n_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_HOLD: begin
                if (!rst_int_n) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_SEQ0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_SEQ0: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_SEQ1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_SEQ1: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (sw_rst_req) begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state, yet leave the block straight from flops.
    always_comb begin
        rst_n_d = 3'b000;
        ready_d = 1'b0;
        ack_d   = (state_q == S_RUN) && sw_rst_req;
        unique case (state_d)
            S_HOLD:  rst_n_d = 3'b000;
            S_SEQ0:  rst_n_d = 3'b001;
            S_SEQ1:  rst_n_d = 3'b011;
            S_RUN: begin
                rst_n_d = 3'b111;
                ready_d = 1'b1;
            end
            default: rst_n_d = 3'b000;
        endcase
    end

    assign rst_n_o    = rst_n_q;
    assign sys_ready  = ready_q;
    assign sw_rst_ack = ack_q;

endmodule
